cache_miss_controller: RTL and testbench

Sequencing block that sits directly downstream of the data cache and in front of main data memory. It watches the cache's hit flag for each CPU load or store. On a read miss it stalls the pipeline, fetches the word from memory over a req/ack handshake and writes it into the cache. Stores are written through to memory, and the cached copy is updated only when the store hits. It also keeps saturating access and miss counters for performance measurement.

---
 rtl/cache_miss_controller.sv | 150 +++++++++++++++
 tb/tb_cache_miss_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_controller.sv
// Miss sequencer between the data cache and main memory: stalls on load misses and all stores,
// fetches or writes through over a req/ack handshake, fills the cache, and counts accesses/misses.
module cache_miss_controller #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  input  logic                   req_we_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [DATA_WIDTH-1:0]  req_wdata_i,
  input  logic                   hit_i,
  input  logic [DATA_WIDTH-1:0]  cache_rdata_i,
  output logic                   stall_o,
  output logic [DATA_WIDTH-1:0]  rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  input  logic                   mem_ack_i,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  output logic                   fill_valid_o,
  output logic [ADDR_WIDTH-1:0]  fill_addr_o,
  output logic [DATA_WIDTH-1:0]  fill_data_o,
  output logic [COUNT_WIDTH-1:0] access_count_o,
  output logic [COUNT_WIDTH-1:0] miss_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StWrWait,
    StFill,
    StResp
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   hit_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic                   fill_valid_q;
  logic [DATA_WIDTH-1:0]  fill_data_q;
  logic [COUNT_WIDTH-1:0] access_q;
  logic [COUNT_WIDTH-1:0] miss_q;

  logic idle_req;
  logic idle_exit;
  logic idle_ld_miss;

  assign idle_req     = (state_q == StIdle) && req_valid_i;
  assign idle_exit    = idle_req && (req_we_i || !hit_i);
  assign idle_ld_miss = idle_req && !req_we_i && !hit_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      wdata_q      <= '0;
      hit_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_data_q  <= '0;
      access_q     <= '0;
      miss_q       <= '0;
    end else begin
      if (idle_req && access_q != CountMax) begin
        access_q <= access_q + 1'b1;
      end
      if (idle_ld_miss && miss_q != CountMax) begin
        miss_q <= miss_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (idle_exit) begin
            addr_q    <= req_addr_i;
            mem_req_q <= 1'b1;
            mem_we_q  <= req_we_i;
            if (req_we_i) begin
              wdata_q <= req_wdata_i;
              hit_q   <= hit_i;
              state_q <= StWrWait;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (mem_ack_i) begin
            data_q       <= mem_rdata_i;
            fill_data_q  <= mem_rdata_i;
            fill_valid_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            state_q      <= StFill;
          end
        end
        StWrWait: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            // Store misses are written through only; no line is allocated.
            if (hit_q) begin
              fill_data_q  <= wdata_q;
              fill_valid_q <= 1'b1;
              state_q      <= StFill;
            end else begin
              state_q <= StResp;
            end
          end
        end
        StFill: begin
          fill_valid_q <= 1'b0;
          state_q      <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the offending request freezes the CPU in its own cycle.
  assign stall_o = idle_exit || (state_q == StRdWait) || (state_q == StWrWait) ||
                   (state_q == StFill);
  assign rdata_o = (state_q == StIdle) ? cache_rdata_i : data_q;

  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign fill_valid_o   = fill_valid_q;
  assign fill_addr_o    = addr_q;
  assign fill_data_o    = fill_data_q;
  assign access_count_o = access_q;
  assign miss_count_o   = miss_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Scoreboard bench for cache_miss_controller: stimulus queues expected memory, fill and load
// responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        hit_i = 1'b0;
  logic [31:0] cache_rdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        fill_valid_o;
  logic [31:0] fill_addr_o;
  logic [31:0] fill_data_o;
  logic [15:0] access_count_o;
  logic [15:0] miss_count_o;

  cache_miss_controller #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .COUNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .hit_i         (hit_i),
    .cache_rdata_i (cache_rdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .fill_valid_o  (fill_valid_o),
    .fill_addr_o   (fill_addr_o),
    .fill_data_o   (fill_data_o),
    .access_count_o(access_count_o),
    .miss_count_o  (miss_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fill_t;

  mem_t        mem_q[$];
  fill_t       fill_q[$];
  logic [31:0] rd_q[$];

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_acc  = '0;
  logic [15:0] exp_miss = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Monitor: samples just after negedge, away from the rising edge.
  always @(negedge clk) begin
    mem_t  me;
    fill_t fe;
    #1;
    if (req_valid_i && !req_we_i && !stall_o) begin
      if (rd_q.size() == 0) flag("rdata_unexpected");
      else check("rdata", rdata_o, rd_q.pop_front());
    end
    if (mem_req_o && mem_ack_i) begin
      if (mem_q.size() == 0) flag("mem_unexpected");
      else begin
        me = mem_q.pop_front();
        check("mem_we", 32'(mem_we_o), 32'(me.we));
        check("mem_addr", mem_addr_o, me.addr);
        if (me.we) check("mem_wdata", mem_wdata_o, me.wdata);
      end
    end
    if (fill_valid_o) begin
      if (fill_q.size() == 0) flag("fill_unexpected");
      else begin
        fe = fill_q.pop_front();
        check("fill_addr", fill_addr_o, fe.addr);
        check("fill_data", fill_data_o, fe.data);
      end
    end
  end

  // One CPU access; memory acks on the (k+1)-th cycle mem_req_o is seen high.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic hit, input logic [31:0] crd, input int k,
                        input logic [31:0] mrd, input int exp_stall, input string name);
    int stalls = 0;
    int reqs = 0;
    bit done = 1'b0;
    exp_acc = sat_inc(exp_acc);
    if (!we && !hit) exp_miss = sat_inc(exp_miss);
    if (!we && hit) rd_q.push_back(crd);
    if (!we && !hit) begin
      mem_q.push_back('{we: 1'b0, addr: addr, wdata: 32'h0});
      fill_q.push_back('{addr: addr, data: mrd});
      rd_q.push_back(mrd);
    end
    if (we) begin
      mem_q.push_back('{we: 1'b1, addr: addr, wdata: wdata});
      if (hit) fill_q.push_back('{addr: addr, data: wdata});
    end
    req_valid_i   = 1'b1;
    req_we_i      = we;
    req_addr_i    = addr;
    req_wdata_i   = wdata;
    hit_i         = hit;
    cache_rdata_i = crd;
    mem_rdata_i   = mrd;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        reqs++;
        mem_ack_i = (reqs == k + 1);
      end else begin
        mem_ack_i = 1'b0;
      end
      if (stall_o) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got stall after 64 cycles expected release", name);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    mem_ack_i   = 1'b0;
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, "_access_count"}, 32'(access_count_o), 32'(exp_acc));
    check({name, "_miss_count"}, 32'(miss_count_o), 32'(exp_miss));
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_req", 32'(mem_req_o), 32'h0);
    check("reset_mem_we", 32'(mem_we_o), 32'h0);
    check("reset_fill_valid", 32'(fill_valid_o), 32'h0);
    check("reset_stall", 32'(stall_o), 32'h0);
    check("reset_access", 32'(access_count_o), 32'h0);
    check("reset_miss", 32'(miss_count_o), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ld/st, addr, wdata, hit, cache data, k, mem data, expected stall cycles
    access(1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, 0, 32'h0, 0, "ld_hit");
    access(1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 2, 32'h12345678, 5, "ld_miss_k2");
    access(1'b1, 32'h100, 32'hCAFEF00D, 1'b1, 32'h0, 0, 32'h0, 3, "st_hit_k0");
    access(1'b1, 32'h140, 32'h0BADF00D, 1'b0, 32'h0, 1, 32'h0, 3, "st_miss_k1");
    access(1'b0, 32'hC4, 32'h0, 1'b0, 32'h0, 0, 32'hA5A5_5A5A, 3, "ld_miss_k0");
    access(1'b1, 32'h180, 32'h1357_9BDF, 1'b1, 32'h0, 3, 32'h0, 6, "st_hit_k3");
    access(1'b0, 32'h44, 32'h0, 1'b1, 32'h0F0F_0F0F, 0, 32'h0, 0, "ld_hit_b2b");

    // Reset in the middle of a read miss; the memory never acks before reset.
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h200;
    hit_i       = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rdwait_mem_req", 32'(mem_req_o), 32'h1);
    check("rdwait_stall", 32'(stall_o), 32'h1);
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req_o), 32'h0);
    check("abort_stall", 32'(stall_o), 32'h0);
    check("abort_access", 32'(access_count_o), 32'h0);
    check("abort_miss", 32'(miss_count_o), 32'h0);
    exp_acc  = '0;
    exp_miss = '0;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    check("late_ack_mem_req", 32'(mem_req_o), 32'h0);
    check("late_ack_stall", 32'(stall_o), 32'h0);
    check("late_ack_fill", 32'(fill_valid_o), 32'h0);
    access(1'b0, 32'h48, 32'h0, 1'b1, 32'h2468_ACE0, 0, 32'h0, 0, "post_reset_hit");

    // Drive the access counter up to all-ones minus one with back-to-back hits.
    n = 32'hFFFE - 32'(exp_acc);
    req_valid_i   = 1'b1;
    req_we_i      = 1'b0;
    req_addr_i    = 32'h4C;
    hit_i         = 1'b1;
    cache_rdata_i = 32'h7777_0001;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(32'h7777_0001);
      @(posedge clk);
    end
    #1;
    req_valid_i = 1'b0;
    exp_acc = 16'hFFFE;
    check("preload_access", 32'(access_count_o), 32'hFFFE);
    access(1'b0, 32'h50, 32'h0, 1'b1, 32'h1, 0, 32'h0, 0, "sat_hit1");
    access(1'b0, 32'h54, 32'h0, 1'b1, 32'h2, 0, 32'h0, 0, "sat_hit2");
    access(1'b0, 32'h58, 32'h0, 1'b1, 32'h3, 0, 32'h0, 0, "sat_hit3");
    check("sat_hold", 32'(access_count_o), 32'hFFFF);

    repeat (2) @(posedge clk);
    #1;
    check("queues_drained", 32'(mem_q.size() + fill_q.size() + rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
